pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage LA32R pipeline (IF/ID/EX/MEM/WB).
//  Merges EX branch-redirect, ID load-use, MEM multi-cycle data-access wait and WB halt into
//  per-register stall/flush controls and the PC redirect. Holds a small FSM for memory wait,
//  timeout and halt, plus saturating stall/flush performance counters.
// PARAMETERS
//  CNT_W        32   width of perf counters stall_cnt / flush_cnt (saturating)
//  MEM_TIMEOUT  255  max consecutive MEM_WAIT cycles before mem_err; range 1..2^16-1
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, synchronous, active-high
//  ex_br_valid  in   1   EX instr is a branch/jump (npc_sel != 0)
//  ex_pcadd4    in   32  EX instr PC+4
//  ex_br_target in   32  EX computed next PC
//  id_load_use  in   1   ID instr sources rd of a load currently in EX
//  mem_req      in   1   MEM stage data access in progress
//  mem_ready    in   1   data memory completes access this cycle
//  halt_req     in   1   WB retiring a break/halt instruction
//  pc_stall     out  1   hold PC
//  pc_redirect  out  1   load pc_target into PC
//  pc_target    out  32  redirect target (= ex_br_target)
//  if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall   out 1 each  hold pipeline register
//  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush   out 1 each  load bubble (NOP, valid=0)
//  halted       out  1   pipeline stopped (state HALTED)
//  mem_err      out  1   sticky: memory timeout occurred
//  stall_cnt    out  CNT_W  cycles with pc_stall=1 outside HALTED
//  flush_cnt    out  CNT_W  number of redirects issued
// BEHAVIOUR
//  - All stall/flush/redirect outputs combinational from state + inputs; forced 0 while rst=1.
//  - rst: state<=RUN, wait counter<=0, mem_err<=0, stall_cnt<=0, flush_cnt<=0. Legal mid-MEM_WAIT.
//  - mispredict = ex_br_valid && (ex_br_target != ex_pcadd4); freeze = mem_req && !mem_ready.
//  - Priority in RUN/MEM_WAIT, highest first:
//    1 halt_req: all *_stall=1, pc_stall=1, no flush/redirect; next state HALTED.
//    2 freeze: pc_stall, if_id/id_ex/ex_mem_stall=1, mem_wb_flush=1; mispredict/load-use ignored
//      (EX instr held, re-evaluated when freeze ends).
//    3 mispredict: pc_redirect=1, pc_target=ex_br_target, if_id_flush=id_ex_flush=1; load-use ignored.
//    4 id_load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1.
//    5 otherwise all 0.
//  - FSM: RUN --freeze--> MEM_WAIT; MEM_WAIT --mem_ready or !mem_req--> RUN;
//    MEM_WAIT stays while freeze, wait counter +1 per cycle; counter cleared on entering RUN.
//    Counter reaching MEM_TIMEOUT while freeze: mem_err<=1, next state HALTED.
//    The cycle mem_ready=1 is a normal advancing cycle (priorities 3-5 apply).
//  - HALTED: all *_stall=1, pc_stall=1, flushes/redirect 0, halted=1; exit only by rst; inputs ignored.
//  - Counters saturate at all-ones; stall_cnt +1 per cycle with pc_stall=1 and state!=HALTED
//    (includes halt_req cycle); flush_cnt +1 per cycle with pc_redirect=1. Both update on clock edge.
// STRUCTURE
//  - Package pipe_ctrl_pkg: state enum {RUN, MEM_WAIT, HALTED} (2 bits), NOP instruction constant
//    (0x03400000, andi r0,r0,0), priority encoding constants.
//  - Sub-module sat_counter #(W) (en, clr, q) instantiated twice for stall_cnt/flush_cnt.
//  - Datapath flush logic subsumed: mispredict compare lives here, no separate flush block.
// TESTING
//  1 ex_br_valid=1, pcadd4=0x1C000010, target=0x1C000040 -> same cycle pc_redirect=1,
//    pc_target=0x1C000040, if_id_flush=id_ex_flush=1; flush_cnt 0->1 next edge.
//  2 ex_br_valid=1, target=pcadd4=0x1C000010 -> no redirect/flush; with id_load_use=1 too ->
//    pc_stall=if_id_stall=id_ex_flush=1, stall_cnt +1; add mispredict -> redirect only, stall_cnt unchanged.
//  3 mem_req=1, mem_ready=0 for 3 cycles then 1 -> freeze outputs cycles 1-3 (mem_wb_flush=1),
//    state MEM_WAIT after cycle 1, cycle 4 normal, state RUN after; stall_cnt +3; held mispredict
//    redirects in cycle 4.
//  4 MEM_TIMEOUT=4, mem_req=1, mem_ready never -> mem_err=1 and halted=1 after timeout; all stalls 1.
//  5 halt_req=1 in RUN -> all stalls 1 that cycle, halted=1 next cycle, persists while inputs toggle.
//  6 rst=1 during MEM_WAIT with counters nonzero -> outputs 0 during rst, then RUN, counters 0, mem_err 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_t   : controller FSM state (RUN / MEM_WAIT / HALTED)
//   prio_t    : resolved hazard class for the current cycle, highest wins
//   NOP_INSTR : bubble instruction loaded by a flushed pipeline register
//   prio_sel  : priority encoder over the raw hazard conditions
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  // andi r0,r0,0
  localparam logic [31:0] NOP_INSTR = 32'h0340_0000;

  typedef enum logic [2:0] {
    PRIO_NONE     = 3'd0,
    PRIO_LOAD_USE = 3'd1,
    PRIO_REDIRECT = 3'd2,
    PRIO_FREEZE   = 3'd3,
    PRIO_HALT     = 3'd4
  } prio_t;

  function automatic prio_t prio_sel(input logic halt, input logic freeze,
                                     input logic mispredict, input logic load_use);
    if (halt)            return PRIO_HALT;
    else if (freeze)     return PRIO_FREEZE;
    else if (mispredict) return PRIO_REDIRECT;
    else if (load_use)   return PRIO_LOAD_USE;
    else                 return PRIO_NONE;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard bus between the pipeline datapath and the stall/flush scheduler.
//   master : pipeline side, drives hazard sources, receives stall/flush/redirect
//   slave  : scheduler side
interface pipe_hazard_ctrl_if;
  logic        ex_br_valid;
  logic [31:0] ex_pcadd4;
  logic [31:0] ex_br_target;
  logic        id_load_use;
  logic        mem_req;
  logic        mem_ready;
  logic        halt_req;

  logic        pc_stall;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;

  modport master (
    output ex_br_valid, ex_pcadd4, ex_br_target, id_load_use, mem_req, mem_ready, halt_req,
    input  pc_stall, pc_redirect, pc_target,
    input  if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
    input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush
  );

  modport slave (
    input  ex_br_valid, ex_pcadd4, ex_br_target, id_load_use, mem_req, mem_ready, halt_req,
    output pc_stall, pc_redirect, pc_target,
    output if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
    output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk : clock      clr : sync clear (wins over en)
//   en  : count      q   : value, sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (clr)                 q <= '0;
    else if (en && ~&q)      q <= q + 1'b1;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
//   clk, rst   : clock, synchronous active-high reset
//   hz         : hazard bus (slave) - hazard sources in, stall/flush/redirect out
//   halted     : pipeline stopped, left only through rst
//   mem_err    : sticky, data access exceeded MEM_TIMEOUT wait cycles
//   stall_cnt  : saturating count of pc_stall cycles outside HALTED
//   flush_cnt  : saturating count of redirects
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave hz,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [15:0] wcnt;
  logic        mispredict, freeze;
  prio_t       prio;

  assign mispredict = hz.ex_br_valid && (hz.ex_br_target != hz.ex_pcadd4);
  assign freeze     = hz.mem_req && !hz.mem_ready;
  // HALTED looks exactly like a halt request on the control outputs.
  assign prio       = prio_sel(state == ST_HALTED || hz.halt_req, freeze, mispredict,
                               hz.id_load_use);
  assign halted     = (state == ST_HALTED);
  assign hz.pc_target = hz.ex_br_target;

  always_comb begin
    hz.pc_stall     = 1'b0;
    hz.pc_redirect  = 1'b0;
    hz.if_id_stall  = 1'b0;
    hz.id_ex_stall  = 1'b0;
    hz.ex_mem_stall = 1'b0;
    hz.mem_wb_stall = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.ex_mem_flush = 1'b0;
    hz.mem_wb_flush = 1'b0;
    if (!rst) begin
      case (prio)
        PRIO_HALT: begin
          hz.pc_stall     = 1'b1;
          hz.if_id_stall  = 1'b1;
          hz.id_ex_stall  = 1'b1;
          hz.ex_mem_stall = 1'b1;
          hz.mem_wb_stall = 1'b1;
        end
        // Hold everything up to MEM; WB gets a bubble while the access is pending.
        PRIO_FREEZE: begin
          hz.pc_stall     = 1'b1;
          hz.if_id_stall  = 1'b1;
          hz.id_ex_stall  = 1'b1;
          hz.ex_mem_stall = 1'b1;
          hz.mem_wb_flush = 1'b1;
        end
        PRIO_REDIRECT: begin
          hz.pc_redirect  = 1'b1;
          hz.if_id_flush  = 1'b1;
          hz.id_ex_flush  = 1'b1;
        end
        PRIO_LOAD_USE: begin
          hz.pc_stall     = 1'b1;
          hz.if_id_stall  = 1'b1;
          hz.id_ex_flush  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hz.halt_req) state <= ST_HALTED;
          else if (freeze) begin
            state <= ST_MEM_WAIT;
            wcnt  <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (hz.halt_req) state <= ST_HALTED;
          else if (freeze) begin
            if (wcnt == WAIT_LAST) begin
              mem_err <= 1'b1;
              state   <= ST_HALTED;
            end else begin
              wcnt <= wcnt + 16'd1;
            end
          end else begin
            state <= ST_RUN;
            wcnt  <= '0;
          end
        end
        // HALTED and the unused encoding both park in HALTED.
        default: state <= ST_HALTED;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (hz.pc_stall && state != ST_HALTED),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .en  (hz.pc_redirect),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz ();
  pipe_hazard_ctrl_if hz2 ();

  // Second instance has 2-bit counters to reach saturation quickly.
  assign hz2.ex_br_valid  = hz.ex_br_valid;
  assign hz2.ex_pcadd4    = hz.ex_pcadd4;
  assign hz2.ex_br_target = hz.ex_br_target;
  assign hz2.id_load_use  = hz.id_load_use;
  assign hz2.mem_req      = hz.mem_req;
  assign hz2.mem_ready    = hz.mem_ready;
  assign hz2.halt_req     = hz.halt_req;

  logic        halted, mem_err, halted2, mem_err2;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  stall_cnt2, flush_cnt2;

  pipe_hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .hz(hz.slave), .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut2 (
    .clk(clk), .rst(rst), .hz(hz2.slave), .halted(halted2), .mem_err(mem_err2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  // {pc_stall, pc_redirect, if_id/id_ex/ex_mem/mem_wb stall, if_id/id_ex/ex_mem/mem_wb flush}
  logic [9:0] ctl;
  assign ctl = {hz.pc_stall, hz.pc_redirect,
                hz.if_id_stall, hz.id_ex_stall, hz.ex_mem_stall, hz.mem_wb_stall,
                hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.mem_wb_flush};

  localparam logic [9:0] C_NONE   = 10'b0_0_0000_0000;
  localparam logic [9:0] C_HALT   = 10'b1_0_1111_0000;
  localparam logic [9:0] C_FREEZE = 10'b1_0_1110_0001;
  localparam logic [9:0] C_REDIR  = 10'b0_1_0000_1100;
  localparam logic [9:0] C_LU     = 10'b1_0_1000_0100;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    hz.ex_br_valid  = 1'b0;
    hz.ex_pcadd4    = 32'h0;
    hz.ex_br_target = 32'h0;
    hz.id_load_use  = 1'b0;
    hz.mem_req      = 1'b0;
    hz.mem_ready    = 1'b0;
    hz.halt_req     = 1'b0;
  endtask

  task automatic set_br(input logic [31:0] pcadd4, input logic [31:0] target);
    hz.ex_br_valid  = 1'b1;
    hz.ex_pcadd4    = pcadd4;
    hz.ex_br_target = target;
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_mem_err", 64'(mem_err), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    set_br(32'h1C00_0010, 32'h1C00_0040);
    hz.halt_req = 1'b1;
    #1 chk("rst_mask", 64'(ctl), 64'(C_NONE));
    clr_in();
    rst = 1'b0;
    cyc();

    // 1: taken branch redirects in the same cycle
    set_br(32'h1C00_0010, 32'h1C00_0040);
    #1 chk("t1_ctl", 64'(ctl), 64'(C_REDIR));
    chk("t1_target", 64'(hz.pc_target), 64'h1C00_0040);
    cyc();
    chk("t1_flush_cnt", 64'(flush_cnt), 64'd1);
    chk("t1_stall_cnt", 64'(stall_cnt), 64'd0);
    clr_in();

    // 2: correctly predicted branch, then load-use, then load-use masked by mispredict
    set_br(32'h1C00_0010, 32'h1C00_0010);
    #1 chk("t2_nobr", 64'(ctl), 64'(C_NONE));
    hz.id_load_use = 1'b1;
    #1 chk("t2_lu", 64'(ctl), 64'(C_LU));
    cyc();
    chk("t2_lu_stall_cnt", 64'(stall_cnt), 64'd1);
    hz.ex_br_target = 32'h1C00_0040;
    #1 chk("t2_lu_redir", 64'(ctl), 64'(C_REDIR));
    cyc();
    chk("t2_stall_cnt", 64'(stall_cnt), 64'd1);
    chk("t2_flush_cnt", 64'(flush_cnt), 64'd2);
    clr_in();

    // 3: 3-cycle memory wait with a held mispredict behind it
    set_br(32'h1C00_0010, 32'h1C00_0040);
    hz.mem_req = 1'b1;
    #1 chk("t3_c1", 64'(ctl), 64'(C_FREEZE));
    cyc();
    chk("t3_state_wait", 64'(dut.state), 64'(ST_MEM_WAIT));
    chk("t3_c2", 64'(ctl), 64'(C_FREEZE));
    cyc();
    chk("t3_c3", 64'(ctl), 64'(C_FREEZE));
    cyc();
    hz.mem_ready = 1'b1;
    #1 chk("t3_c4", 64'(ctl), 64'(C_REDIR));
    cyc();
    chk("t3_state_run", 64'(dut.state), 64'(ST_RUN));
    chk("t3_stall_cnt", 64'(stall_cnt), 64'd4);
    chk("t3_flush_cnt", 64'(flush_cnt), 64'd3);
    chk("t3_flush_cnt2", 64'(flush_cnt2), 64'd3);
    clr_in();

    // 6: reset in the middle of a memory wait
    hz.mem_req = 1'b1;
    cyc();
    chk("t6_state_wait", 64'(dut.state), 64'(ST_MEM_WAIT));
    chk("t6_stall_cnt", 64'(stall_cnt), 64'd5);
    rst = 1'b1;
    #1 chk("t6_rst_mask", 64'(ctl), 64'(C_NONE));
    cyc();
    chk("t6_state_run", 64'(dut.state), 64'(ST_RUN));
    chk("t6_stall_cnt0", 64'(stall_cnt), 64'd0);
    chk("t6_flush_cnt0", 64'(flush_cnt), 64'd0);
    chk("t6_mem_err", 64'(mem_err), 64'd0);
    rst = 1'b0;
    clr_in();

    // 4: memory never ready; timeout after 1 RUN + 4 MEM_WAIT freeze cycles
    hz.mem_req = 1'b1;
    repeat (4) cyc();
    chk("t4_pre_halted", 64'(halted), 64'd0);
    chk("t4_pre_mem_err", 64'(mem_err), 64'd0);
    chk("t4_pre_stall_cnt", 64'(stall_cnt), 64'd4);
    chk("t4_pre_stall_cnt2", 64'(stall_cnt2), 64'd3);
    cyc();
    chk("t4_halted", 64'(halted), 64'd1);
    chk("t4_mem_err", 64'(mem_err), 64'd1);
    chk("t4_mem_err2", 64'(mem_err2), 64'd1);
    chk("t4_stall_cnt", 64'(stall_cnt), 64'd5);
    chk("t4_stall_cnt2_sat", 64'(stall_cnt2), 64'd3);
    chk("t4_ctl", 64'(ctl), 64'(C_HALT));
    hz.mem_req = 1'b0;
    set_br(32'h1C00_0010, 32'h1C00_0040);
    hz.id_load_use = 1'b1;
    #1 chk("t4_ctl_toggle", 64'(ctl), 64'(C_HALT));
    cyc();
    chk("t4_halted_hold", 64'(halted), 64'd1);
    chk("t4_stall_cnt_hold", 64'(stall_cnt), 64'd5);
    chk("t4_flush_cnt_hold", 64'(flush_cnt), 64'd0);

    rst = 1'b1;
    clr_in();
    cyc();
    rst = 1'b0;
    chk("t4_rst_mem_err", 64'(mem_err), 64'd0);
    chk("t4_rst_halted", 64'(halted), 64'd0);

    // 5: halt request from RUN
    hz.halt_req = 1'b1;
    #1 chk("t5_ctl", 64'(ctl), 64'(C_HALT));
    cyc();
    chk("t5_halted", 64'(halted), 64'd1);
    chk("t5_stall_cnt", 64'(stall_cnt), 64'd1);
    hz.halt_req = 1'b0;
    set_br(32'h1C00_0010, 32'h1C00_0040);
    #1 chk("t5_ctl_hold", 64'(ctl), 64'(C_HALT));
    cyc();
    chk("t5_halted_hold", 64'(halted), 64'd1);
    chk("t5_halted2", 64'(halted2), 64'd1);
    chk("t5_stall_cnt_hold", 64'(stall_cnt), 64'd1);
    chk("t5_flush_cnt", 64'(flush_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
